forward_operand_mux: RTL and testbench
======================================

Name: forward_operand_mux

Overview:
- Consumer side of the forwarding unit.
- Keeps a two-deep history of write-back candidates from the previous (P1) and previous-previous (P2) instructions: ALU out, memory data, input port, immediate.
- Decodes the registered forward_A/forward_B select codes and drives the ALU A/B operands.
- Raises the load-use stall when P1's memory data has not yet returned.

Parameters:
- DW, 8, datapath width.
- STALL_MAX, 4, maximum consecutive load-use stall cycles before mem_timeout is flagged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- adv  in  1  pipeline advance; shifts history P2<=P1, P1<=capture inputs.
- flush  in  1  invalidates P1 and P2.
- cap_alu  in  DW  ALU result of the instruction entering history.
- cap_in  in  DW  input-port value of the instruction entering history.
- cap_imm  in  DW  immediate of the instruction entering history.
- cap_is_load  in  1  the entering instruction's memory data is pending.
- mem_rdata  in  DW  late memory read data for P1.
- mem_rvalid  in  1  mem_rdata valid for P1 this cycle.
- rf_a  in  DW  register-file read data, port A.
- rf_b  in  DW  register-file read data, port B.
- forward_A  in  4  select code, A.
- forward_B  in  4  select code, B.
- op_a  out  DW  ALU operand A (registered).
- op_b  out  DW  ALU operand B (registered).
- op_valid  out  1  op_a/op_b valid this cycle.
- stall  out  1  load-use stall request to the hazard/PC logic (combinational).
- fwd_err  out  1  one-cycle pulse on an illegal select code.
- mem_timeout  out  1  sticky; set when stall persists STALL_MAX cycles.

Behaviour:
- Reset (rst_n=0, async):
  - All history fields 0; valid and pending bits 0.
  - op_a=0, op_b=0, op_valid=0, fwd_err=0, mem_timeout=0, stall counter 0.
- History:
  - Each stage holds alu, mem, in, imm (DW each) plus valid and mem_pending.
  - On adv=1 and stall=0:
    - P2<=P1.
    - P1.alu/in/imm <= cap_*.
    - P1.mem <= 0.
    - P1.valid <= 1.
    - P1.mem_pending <= cap_is_load.
  - adv while stall=1 is ignored.
  - mem_rvalid=1 with P1.mem_pending=1: P1.mem<=mem_rdata, pending<=0.
  - mem_rvalid when P1 is not pending is ignored.
  - Simultaneous mem_rvalid and a legal shift: the data is written into the stage moving to P2.
- flush=1: P1/P2 valid<=0, pending<=0, stall counter<=0. flush has priority over adv.
- Code decode, per port independently:
  - 0010: rf.
  - 0000: P1.mem.
  - 0001: P1.alu.
  - 0011: P1.in.
  - 0100: P1.imm.
  - 1000: P2.mem.
  - 1001: P2.alu.
  - 1011: P2.in.
  - 1100: P2.imm.
  - Code referencing an invalid stage: select rf, no error.
  - Any other code: select rf and pulse fwd_err for one cycle.
- stall = P1.valid & P1.mem_pending & (forward_A==0000 | forward_B==0000) & ~flush.
  - If mem_rvalid is high in the same cycle, stall=0 and mem_rdata is bypassed directly into the operand.
- Operand register:
  - Each cycle: op_a/op_b <= decoded values.
  - op_valid <= ~stall & ~flush.
  - Latency: 1 cycle from code/data to op_*.
  - During stall, op_a/op_b hold their previous values and op_valid=0.
- Stall counter:
  - Increments while stall=1; clears when stall=0.
  - Reaching STALL_MAX sets mem_timeout, cleared only by reset.
  - The counter saturates at STALL_MAX.
- Both ports selecting the same source is legal; no arbitration.

Test Plan:
- Reset mid-run: drive adv with cap_alu=0x5A, then pull rst_n low asynchronously -> op_a=op_b=0 and op_valid=0 immediately; a later code 0001 selects rf_a.
- Two-deep shift: adv with cap_alu=0x11, then adv with cap_alu=0x22; forward_A=1001, forward_B=0001 -> next cycle op_a=0x11, op_b=0x22, op_valid=1.
- Load-use: adv with cap_is_load=1, forward_A=0000, mem_rvalid held low 2 cycles then mem_rdata=0x3C -> stall=1 for 2 cycles, op_valid=0, adv ignored; the cycle after rvalid gives op_a=0x3C.
- Timeout: pending load, forward_B=0000, no rvalid for 4 cycles -> mem_timeout=1 on the 4th stall cycle and stays set after the data arrives.
- Illegal and default codes: forward_A=0101, rf_a=0x77 -> op_a=0x77 with a one-cycle fwd_err pulse; code 0010 gives op_a=rf_a with no error.
- Flush: P1.alu=0x44, flush=1, then forward_A=0001 -> op_a=rf_a and stall=0, even if P1 had been a pending load.

Source files
------------

// File: rtl/forward_operand_mux_if.sv
// rtl/forward_operand_mux_if.sv - forwarding consumer bus: history capture, memory return, selects and operands
interface forward_operand_mux_if #(
    parameter int DW = 8
);
    logic          adv;
    logic          flush;
    logic [DW-1:0] cap_alu;
    logic [DW-1:0] cap_in;
    logic [DW-1:0] cap_imm;
    logic          cap_is_load;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [DW-1:0] rf_a;
    logic [DW-1:0] rf_b;
    logic [3:0]    forward_A;
    logic [3:0]    forward_B;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_valid;
    logic          stall;
    logic          fwd_err;
    logic          mem_timeout;

    modport master (
        output adv, flush, cap_alu, cap_in, cap_imm, cap_is_load,
        output mem_rdata, mem_rvalid, rf_a, rf_b, forward_A, forward_B,
        input  op_a, op_b, op_valid, stall, fwd_err, mem_timeout
    );

    modport slave (
        input  adv, flush, cap_alu, cap_in, cap_imm, cap_is_load,
        input  mem_rdata, mem_rvalid, rf_a, rf_b, forward_A, forward_B,
        output op_a, op_b, op_valid, stall, fwd_err, mem_timeout
    );
endinterface

// File: rtl/forward_operand_mux.sv
// rtl/forward_operand_mux.sv - two-deep write-back history, forward select decode and load-use stall
module forward_operand_mux #(
    parameter int DW        = 8,
    parameter int STALL_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    forward_operand_mux_if.slave bus
);
    localparam int CW = $clog2(STALL_MAX + 1);

    // P1 = previous instruction, P2 = the one before it.
    logic          p1_valid, p1_pend;
    logic [DW-1:0] p1_alu, p1_mem, p1_in, p1_imm;
    logic          p2_valid;
    logic [DW-1:0] p2_alu, p2_mem, p2_in, p2_imm;

    logic [DW-1:0] op_a_q, op_b_q;
    logic          op_valid_q, fwd_err_q, mem_timeout_q;
    logic [CW-1:0] stall_cnt;

    logic          mem_fill;
    logic [DW-1:0] p1_mem_eff;
    logic          uses_p1_mem;
    logic          stall;
    logic          shift;

    logic [1:0][3:0]    code;
    logic [1:0][DW-1:0] rf;
    logic [1:0][DW-1:0] sel;
    logic [1:0]         illegal;

    // Late memory data is visible the same cycle it returns, so a waiting
    // consumer is released immediately instead of burning one more stall.
    assign mem_fill    = p1_pend & bus.mem_rvalid;
    assign p1_mem_eff  = mem_fill ? bus.mem_rdata : p1_mem;
    assign uses_p1_mem = (bus.forward_A == 4'b0000) | (bus.forward_B == 4'b0000);
    assign stall       = p1_valid & p1_pend & uses_p1_mem & ~bus.flush & ~bus.mem_rvalid;
    assign shift       = bus.adv & ~stall;

    assign code[0] = bus.forward_A;
    assign code[1] = bus.forward_B;
    assign rf[0]   = bus.rf_a;
    assign rf[1]   = bus.rf_b;

    // Per-port source decode; an invalid stage quietly falls back to the register file.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sel[i]     = rf[i];
            illegal[i] = 1'b0;
            case (code[i])
                4'b0010: sel[i] = rf[i];
                4'b0000: if (p1_valid) sel[i] = p1_mem_eff;
                4'b0001: if (p1_valid) sel[i] = p1_alu;
                4'b0011: if (p1_valid) sel[i] = p1_in;
                4'b0100: if (p1_valid) sel[i] = p1_imm;
                4'b1000: if (p2_valid) sel[i] = p2_mem;
                4'b1001: if (p2_valid) sel[i] = p2_alu;
                4'b1011: if (p2_valid) sel[i] = p2_in;
                4'b1100: if (p2_valid) sel[i] = p2_imm;
                default: illegal[i] = 1'b1;
            endcase
        end
    end

    // History shift, flush and late memory fill; flush wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_pend  <= 1'b0;
            p1_alu   <= '0;
            p1_mem   <= '0;
            p1_in    <= '0;
            p1_imm   <= '0;
            p2_valid <= 1'b0;
            p2_alu   <= '0;
            p2_mem   <= '0;
            p2_in    <= '0;
            p2_imm   <= '0;
        end else if (bus.flush) begin
            p1_valid <= 1'b0;
            p1_pend  <= 1'b0;
            p2_valid <= 1'b0;
        end else if (shift) begin
            // Data returning on the shift cycle travels with its instruction into P2.
            p2_valid <= p1_valid;
            p2_alu   <= p1_alu;
            p2_mem   <= p1_mem_eff;
            p2_in    <= p1_in;
            p2_imm   <= p1_imm;
            p1_valid <= 1'b1;
            p1_pend  <= bus.cap_is_load;
            p1_alu   <= bus.cap_alu;
            p1_mem   <= '0;
            p1_in    <= bus.cap_in;
            p1_imm   <= bus.cap_imm;
        end else if (mem_fill) begin
            p1_mem  <= bus.mem_rdata;
            p1_pend <= 1'b0;
        end
    end

    // Operand register: holds its value through a stall, valid drops on stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            fwd_err_q  <= 1'b0;
        end else begin
            if (!stall) begin
                op_a_q <= sel[0];
                op_b_q <= sel[1];
            end
            op_valid_q <= ~stall & ~bus.flush;
            fwd_err_q  <= |illegal;
        end
    end

    // Saturating count of consecutive stall cycles; timeout is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CW'(STALL_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall && (stall_cnt >= CW'(STALL_MAX - 1))) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_valid    = op_valid_q;
    assign bus.stall       = stall;
    assign bus.fwd_err     = fwd_err_q;
    assign bus.mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_forward_operand_mux.sv
// tb/tb_forward_operand_mux.sv - self-checking bench for forward_operand_mux
module tb_forward_operand_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    forward_operand_mux_if #(.DW(8)) bus ();

    forward_operand_mux #(.DW(8), .STALL_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit       v;
        bit       pend;
        logic [7:0] alu;
        logic [7:0] mem;
        logic [7:0] inp;
        logic [7:0] imm;
    } stage_t;

    stage_t     h [2];
    logic [7:0] e_a, e_b;
    bit         e_valid, e_err, e_to;
    int         scnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd11, 4'd12};
    endfunction

    function automatic bit m_stall();
        return h[0].v && h[0].pend && (bus.forward_A == 4'd0 || bus.forward_B == 4'd0)
               && !bus.flush && !bus.mem_rvalid;
    endfunction

    function automatic logic [7:0] pick(input logic [3:0] c, input logic [7:0] rfv);
        int     st;
        stage_t s;
        if (!legal(c) || c == 4'b0010) return rfv;
        st = c[3] ? 1 : 0;
        s  = h[st];
        if (!s.v) return rfv;
        case (c[2:0])
            3'd0:    return (st == 0 && s.pend && bus.mem_rvalid) ? bus.mem_rdata : s.mem;
            3'd1:    return s.alu;
            3'd3:    return s.inp;
            default: return s.imm;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            h[i].v = 0; h[i].pend = 0;
            h[i].alu = 0; h[i].mem = 0; h[i].inp = 0; h[i].imm = 0;
        end
        e_a = 0; e_b = 0; e_valid = 0; e_err = 0; e_to = 0; scnt = 0;
    endtask

    // Advance the model by one clock using the inputs that are about to be sampled.
    task automatic model_step();
        bit st;
        if (!rst_n) begin
            model_reset();
            return;
        end
        st = m_stall();
        if (!st) begin
            e_a = pick(bus.forward_A, bus.rf_a);
            e_b = pick(bus.forward_B, bus.rf_b);
        end
        e_valid = !st && !bus.flush;
        e_err   = !legal(bus.forward_A) || !legal(bus.forward_B);
        if (st) begin
            if (scnt < 4) scnt++;
        end else begin
            scnt = 0;
        end
        if (scnt >= 4) e_to = 1;
        if (bus.flush) begin
            h[0].v = 0; h[0].pend = 0; h[1].v = 0;
        end else begin
            if (h[0].pend && bus.mem_rvalid) begin
                h[0].mem  = bus.mem_rdata;
                h[0].pend = 0;
            end
            if (bus.adv && !st) begin
                h[1]      = h[0];
                h[0].v    = 1;
                h[0].pend = bus.cap_is_load;
                h[0].alu  = bus.cap_alu;
                h[0].mem  = 0;
                h[0].inp  = bus.cap_in;
                h[0].imm  = bus.cap_imm;
            end
        end
    endtask

    task automatic compare_outputs();
        chk("op_a", 32'(bus.op_a), 32'(e_a));
        chk("op_b", 32'(bus.op_b), 32'(e_b));
        chk("op_valid", 32'(bus.op_valid), 32'(e_valid));
        chk("fwd_err", 32'(bus.fwd_err), 32'(e_err));
        chk("mem_timeout", 32'(bus.mem_timeout), 32'(e_to));
        chk("stall", 32'(bus.stall), 32'(m_stall()));
    endtask

    // One clock: compare outputs late in the cycle, step the model, then land 1ns past the edge.
    task automatic cyc();
        #3;
        if (chk_en) compare_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.adv = 0; bus.flush = 0; bus.cap_is_load = 0; bus.mem_rvalid = 0;
        bus.forward_A = 4'b0010; bus.forward_B = 4'b0010;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1);
    end

    initial begin
        idle();
        bus.cap_alu = 0; bus.cap_in = 0; bus.cap_imm = 0;
        bus.mem_rdata = 0; bus.rf_a = 0; bus.rf_b = 0;
        model_reset();
        rst_n = 0;
        cyc(); cyc();
        chk("rst op_a", 32'(bus.op_a), 32'h0);
        chk("rst op_b", 32'(bus.op_b), 32'h0);
        chk("rst op_valid", 32'(bus.op_valid), 32'h0);
        chk("rst fwd_err", 32'(bus.fwd_err), 32'h0);
        chk("rst mem_timeout", 32'(bus.mem_timeout), 32'h0);
        rst_n  = 1;
        chk_en = 1;

        // Reset mid-run
        bus.adv = 1; bus.cap_alu = 8'h5A; bus.cap_in = 8'hA1; bus.cap_imm = 8'hB2;
        cyc();
        bus.adv = 0; bus.forward_A = 4'b0001; bus.rf_a = 8'h13;
        cyc();
        chk("pre-reset op_a", 32'(bus.op_a), 32'h5A);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("async rst op_a", 32'(bus.op_a), 32'h0);
        chk("async rst op_b", 32'(bus.op_b), 32'h0);
        chk("async rst op_valid", 32'(bus.op_valid), 32'h0);
        cyc();
        rst_n = 1;
        bus.forward_A = 4'b0001; bus.rf_a = 8'h21;
        cyc();
        chk("post-reset 0001 -> rf_a", 32'(bus.op_a), 32'h21);

        // Two-deep shift
        idle();
        bus.adv = 1; bus.cap_alu = 8'h11;
        cyc();
        bus.cap_alu = 8'h22;
        cyc();
        bus.adv = 0; bus.forward_A = 4'b1001; bus.forward_B = 4'b0001;
        cyc();
        chk("shift op_a", 32'(bus.op_a), 32'h11);
        chk("shift op_b", 32'(bus.op_b), 32'h22);
        chk("shift op_valid", 32'(bus.op_valid), 32'h1);

        // Load-use with two stall cycles then bypass on return
        idle();
        bus.adv = 1; bus.cap_alu = 8'h30; bus.cap_is_load = 1;
        cyc();
        bus.cap_is_load = 0; bus.cap_alu = 8'h99;
        bus.forward_A = 4'b0000; bus.rf_b = 8'h05;
        #1;
        chk("load-use stall", 32'(bus.stall), 32'h1);
        cyc();
        chk("stall1 op_valid", 32'(bus.op_valid), 32'h0);
        cyc();
        chk("stall2 op_valid", 32'(bus.op_valid), 32'h0);
        bus.mem_rdata = 8'h3C; bus.mem_rvalid = 1;
        #1;
        chk("rvalid releases stall", 32'(bus.stall), 32'h0);
        cyc();
        chk("bypass op_a", 32'(bus.op_a), 32'h3C);
        chk("bypass op_valid", 32'(bus.op_valid), 32'h1);
        bus.mem_rvalid = 0; bus.adv = 0;
        bus.forward_A = 4'b1000; bus.forward_B = 4'b0001;
        cyc();
        chk("fill moved to P2", 32'(bus.op_a), 32'h3C);
        chk("P1 after shift", 32'(bus.op_b), 32'h99);

        // Timeout
        idle();
        bus.adv = 1; bus.cap_alu = 8'h40; bus.cap_is_load = 1;
        cyc();
        bus.adv = 0; bus.cap_is_load = 0; bus.forward_B = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("timeout not yet", 32'(bus.mem_timeout), 32'h0);
        end
        cyc();
        chk("timeout after 4 stalls", 32'(bus.mem_timeout), 32'h1);
        cyc();
        bus.mem_rdata = 8'h66; bus.mem_rvalid = 1;
        cyc();
        chk("late data op_b", 32'(bus.op_b), 32'h66);
        chk("timeout sticky", 32'(bus.mem_timeout), 32'h1);
        bus.mem_rvalid = 0;
        cyc();

        // Illegal and default codes
        idle();
        bus.forward_A = 4'b0101; bus.rf_a = 8'h77; bus.rf_b = 8'h12;
        cyc();
        chk("illegal op_a", 32'(bus.op_a), 32'h77);
        chk("illegal fwd_err", 32'(bus.fwd_err), 32'h1);
        bus.forward_A = 4'b0010; bus.rf_a = 8'h78;
        cyc();
        chk("rf op_a", 32'(bus.op_a), 32'h78);
        chk("fwd_err one cycle", 32'(bus.fwd_err), 32'h0);
        bus.forward_B = 4'b1111;
        cyc();
        chk("illegal B op_b", 32'(bus.op_b), 32'h12);
        chk("illegal B fwd_err", 32'(bus.fwd_err), 32'h1);

        // Flush
        idle();
        bus.adv = 1; bus.cap_alu = 8'h44; bus.cap_is_load = 1;
        cyc();
        bus.adv = 0; bus.cap_is_load = 0;
        bus.forward_A = 4'b0001; bus.forward_B = 4'b0000;
        #1;
        chk("pre-flush stall", 32'(bus.stall), 32'h1);
        bus.flush = 1;
        #1;
        chk("flush masks stall", 32'(bus.stall), 32'h0);
        cyc();
        chk("flush op_valid", 32'(bus.op_valid), 32'h0);
        bus.flush = 0; bus.rf_a = 8'h5B; bus.rf_b = 8'h6C;
        #1;
        chk("post-flush stall", 32'(bus.stall), 32'h0);
        cyc();
        chk("post-flush op_a", 32'(bus.op_a), 32'h5B);
        chk("post-flush op_b", 32'(bus.op_b), 32'h6C);
        chk("post-flush op_valid", 32'(bus.op_valid), 32'h1);
        bus.forward_A = 4'b1001;
        cyc();
        chk("P2 invalid -> rf", 32'(bus.op_a), 32'h5B);
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
